// File: rtl/bit2word_trans_unit.sv
// bit2word_trans_unit: collects 8 LSB-first bit-planes, then emits one 8-bit word per channel 0..ch_last
module bit2word_trans_unit #(
  parameter int MAX_CHANNEL_NUM = 128,
  parameter int CW = $clog2(MAX_CHANNEL_NUM)
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [MAX_CHANNEL_NUM-1:0] bitpar_data_i,
  input  logic                       bitpar_data_vld_i,
  output logic                       bitpar_data_rdy_o,
  input  logic [CW-1:0]              channel_num_i,
  output logic [7:0]                 wordser_data_o,
  output logic                       wordser_data_vld_o,
  input  logic                       wordser_data_rdy_i,
  input  logic                       clear_i,
  output logic                       packet_sent_o,
  output logic                       busy_o
);
  typedef enum logic {COLLECT, SEND} state_t;
  state_t        state, state_nxt;
  logic [2:0]    plane_cnt;
  logic [CW-1:0] word_cnt, ch_last;
  logic [7:0]    trans_buf [MAX_CHANNEL_NUM];
  logic          in_fire, out_fire, last_word;
  assign bitpar_data_rdy_o  = state == COLLECT;
  assign wordser_data_vld_o = state == SEND;
  assign wordser_data_o     = trans_buf[word_cnt];
  assign in_fire   = bitpar_data_vld_i && bitpar_data_rdy_o;
  assign out_fire  = wordser_data_vld_o && wordser_data_rdy_i;
  assign last_word = word_cnt == ch_last;
  always_comb begin
    state_nxt = clear_i                                      ? COLLECT :
                (state == COLLECT && in_fire && &plane_cnt)  ? SEND    :
                (state == SEND && out_fire && last_word)     ? COLLECT : state;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= COLLECT;
    else          state <= state_nxt;
  end
  // clear_i leaves trans_buf alone: every bit is rewritten by the next packet
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      plane_cnt     <= '0;
      word_cnt      <= '0;
      ch_last       <= '0;
      busy_o        <= 1'b0;
      packet_sent_o <= 1'b0;
      for (int i = 0; i < MAX_CHANNEL_NUM; i++) trans_buf[i] <= '0;
    end else if (clear_i) begin
      plane_cnt     <= '0;
      word_cnt      <= '0;
      busy_o        <= 1'b0;
      packet_sent_o <= 1'b0;
    end else begin
      packet_sent_o <= out_fire && last_word;
      if (in_fire) begin
        for (int i = 0; i < MAX_CHANNEL_NUM; i++) trans_buf[i][plane_cnt] <= bitpar_data_i[i];
        plane_cnt <= plane_cnt + 3'd1;
        if (plane_cnt == 3'd0) begin
          ch_last <= channel_num_i;
          busy_o  <= 1'b1;
        end
      end
      if (out_fire) begin
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
        if (last_word) busy_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bit2word_trans_unit.sv
// tb_bit2word_trans_unit: random packets checked against a per-channel byte model
module tb_bit2word_trans_unit;
  localparam int MAX = 128;
  localparam int CW  = $clog2(MAX);
  logic           clk = 0, rst_n_i = 0;
  logic [MAX-1:0] bitpar_data_i = '0;
  logic           bitpar_data_vld_i = 0, bitpar_data_rdy_o;
  logic [CW-1:0]  channel_num_i = '0;
  logic [7:0]     wordser_data_o;
  logic           wordser_data_vld_o, wordser_data_rdy_i = 0;
  logic           clear_i = 0, packet_sent_o, busy_o;
  int             checks = 0, errors = 0;
  logic [7:0]     bytes [MAX];

  bit2word_trans_unit #(.MAX_CHANNEL_NUM(MAX)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .bitpar_data_i(bitpar_data_i), .bitpar_data_vld_i(bitpar_data_vld_i),
    .bitpar_data_rdy_o(bitpar_data_rdy_o), .channel_num_i(channel_num_i),
    .wordser_data_o(wordser_data_o), .wordser_data_vld_o(wordser_data_vld_o),
    .wordser_data_rdy_i(wordser_data_rdy_i), .clear_i(clear_i),
    .packet_sent_o(packet_sent_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < MAX; i++) bytes[i] = 8'($urandom_range(0, 255));
  endtask

  function automatic logic [MAX-1:0] plane(input int p);
    logic [MAX-1:0] v;
    for (int i = 0; i < MAX; i++) v[i] = ((bytes[i] >> p) & 8'd1) != 0;
    return v;
  endfunction

  task automatic put_planes(input int ch, input bit gaps, input int chg, input int np);
    int  p = 0, cyc = 0;
    logic v;
    while (p < np && cyc < 300) begin
      @(negedge clk);
      cyc++;
      chk("busy_collect", busy_o, p != 0);
      chk("in_rdy", bitpar_data_rdy_o, 1);
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bitpar_data_vld_i = v;
      bitpar_data_i = v ? plane(p) : {4{$urandom}};
      channel_num_i = CW'((p > 0 && chg >= 0) ? chg : ch);
      @(posedge clk);
      if (v) p++;
    end
    @(negedge clk);
    bitpar_data_vld_i = 0;
    if (p < np) chk("plane_timeout", 0, 1);
    if (np == 8) begin
      chk("vld_rise", wordser_data_vld_o, 1);
      chk("in_rdy_send", bitpar_data_rdy_o, 0);
      chk("busy_send", busy_o, 1);
    end
  endtask

  task automatic get_words(input int last, input bit rnd, input int clr);
    int k = 0, cyc = 0;
    logic r;
    while (k <= last && cyc < 3000) begin
      cyc++;
      chk("out_vld", wordser_data_vld_o, 1);
      chk("word", wordser_data_o, bytes[k]);
      chk("in_rdy_hold", bitpar_data_rdy_o, 0);
      chk("sent_early", packet_sent_o, 0);
      if (k == clr) begin
        clear_i = 1;
        wordser_data_rdy_i = 1;
        bitpar_data_vld_i = 0;
        @(negedge clk);
        clear_i = 0;
        wordser_data_rdy_i = 0;
        chk("clr_vld", wordser_data_vld_o, 0);
        chk("clr_busy", busy_o, 0);
        chk("clr_sent", packet_sent_o, 0);
        chk("clr_in_rdy", bitpar_data_rdy_o, 1);
        return;
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wordser_data_rdy_i = r;
      bitpar_data_vld_i = (k == last) ? 1'b0 : 1'($urandom_range(0, 1));
      bitpar_data_i = {4{$urandom}};
      @(negedge clk);
      if (r) k++;
    end
    wordser_data_rdy_i = 0;
    bitpar_data_vld_i = 0;
    if (k <= last) chk("word_timeout", 0, 1);
    chk("sent_pulse", packet_sent_o, 1);
    chk("end_vld", wordser_data_vld_o, 0);
    chk("end_in_rdy", bitpar_data_rdy_o, 1);
    chk("end_busy", busy_o, 0);
    @(negedge clk);
    chk("sent_once", packet_sent_o, 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_rdy"}, bitpar_data_rdy_o, 1);
    chk({tag, "_vld"}, wordser_data_vld_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_sent"}, packet_sent_o, 0);
    chk({tag, "_data"}, wordser_data_o, 0);
  endtask

  initial begin
    #3 reset_checks("rst");
    @(negedge clk) rst_n_i = 1;
    fill();
    for (int k = 0; k < 4; k++) bytes[k] = 8'(8'h10 + k);
    put_planes(3, 0, -1, 8);
    get_words(3, 0, -1);
    fill();
    put_planes(127, 1, -1, 8);
    get_words(127, 1, -1);
    fill();
    bytes[0] = 8'hA5;
    put_planes(0, 0, -1, 8);
    get_words(0, 0, -1);
    fill();
    put_planes(5, 0, 2, 8);
    get_words(5, 1, -1);
    fill();
    put_planes(6, 1, -1, 4);
    clear_i = 1;
    bitpar_data_vld_i = 1;
    bitpar_data_i = plane(4);
    @(negedge clk);
    clear_i = 0;
    bitpar_data_vld_i = 0;
    chk("clrp_vld", wordser_data_vld_o, 0);
    chk("clrp_busy", busy_o, 0);
    chk("clrp_sent", packet_sent_o, 0);
    chk("clrp_in_rdy", bitpar_data_rdy_o, 1);
    fill();
    put_planes(4, 0, -1, 8);
    get_words(4, 0, -1);
    fill();
    put_planes(5, 0, -1, 8);
    get_words(5, 0, 2);
    fill();
    put_planes(3, 1, -1, 8);
    get_words(3, 1, -1);
    fill();
    put_planes(9, 0, -1, 8);
    wordser_data_rdy_i = 1;
    @(negedge clk);
    wordser_data_rdy_i = 0;
    #2 rst_n_i = 0;
    #1 reset_checks("midrst");
    @(negedge clk) rst_n_i = 1;
    for (int n = 0; n < 5; n++) begin
      int ch = $urandom_range(0, MAX - 1);
      fill();
      put_planes(ch, n[0], -1, 8);
      get_words(ch, n[1], -1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit2word_trans_unit.md
Name: bit2word_trans_unit

Overview:
Bit-plane to word-serial transposer, the inverse of the input-buffer word-to-bit converter. It collects 8 bit-parallel beats of MAX_CHANNEL_NUM bits each, one bit-plane per beat with the LSB plane first. It then emits one 8-bit word per channel, in channel order 0..channel_num. It sits on the output-buffer path, between the compute array's bit-serial results and the word-serial packet transmitter.

Parameters:
MAX_CHANNEL_NUM, 128, number of channels and width of the bit-parallel input; CW = $clog2(MAX_CHANNEL_NUM).

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_n_i  input  1  asynchronous active-low reset
bitpar_data_i  input  MAX_CHANNEL_NUM  bit-plane; bit i belongs to channel i
bitpar_data_vld_i  input  1  bit-plane valid
bitpar_data_rdy_o  output  1  ready to accept a bit-plane
channel_num_i  input  CW  index of the last channel to emit; words emitted = channel_num_i+1
wordser_data_o  output  8  word for the current channel
wordser_data_vld_o  output  1  word valid
wordser_data_rdy_i  input  1  downstream ready
clear_i  input  1  synchronous abort; returns to COLLECT
packet_sent_o  output  1  one-cycle pulse when the last word of a packet fires
busy_o  output  1  high from the first accepted bit-plane until packet_sent_o or clear_i

Behaviour:
- Async reset (rst_n_i low) values: state=COLLECT, plane_cnt=0, word_cnt=0, bitpar_data_rdy_o=1, wordser_data_vld_o=0, packet_sent_o=0, busy_o=0, trans_buf all 0, ch_last=0.
- Storage: trans_buf[MAX_CHANNEL_NUM][8]. in_fire = bitpar_data_vld_i && bitpar_data_rdy_o. out_fire = wordser_data_vld_o && wordser_data_rdy_i.
- State COLLECT:
  - bitpar_data_rdy_o=1, wordser_data_vld_o=0.
  - On in_fire, trans_buf[i][plane_cnt] <= bitpar_data_i[i] for all i, then plane_cnt increments.
  - On the first in_fire (plane_cnt==0): latch ch_last <= channel_num_i and set busy_o. Later changes to channel_num_i are ignored until the next packet.
  - On in_fire with plane_cnt==7: plane_cnt <= 0 and go to SEND.
- State SEND:
  - bitpar_data_rdy_o=0; no bit-plane is accepted. wordser_data_vld_o=1 (registered; first asserted the cycle after the 8th in_fire).
  - wordser_data_o = trans_buf[word_cnt], combinational from the registered buffer and counter. It is stable while vld=1 and rdy=0.
  - On out_fire with word_cnt != ch_last: word_cnt increments.
  - On out_fire with word_cnt == ch_last: word_cnt <= 0, packet_sent_o pulses the next cycle, busy_o clears, return to COLLECT. bitpar_data_rdy_o=1 the cycle after the last out_fire.
- Throughput: one word per cycle while wordser_data_rdy_i is held high. Minimum packet time = 8 + (ch_last+1) + 1 cycles.
- Every bit of trans_buf[0..MAX-1] is rewritten each packet, so no explicit buffer clear is needed. Channels above ch_last are never emitted.
- ch_last = MAX_CHANNEL_NUM-1 (all ones): all channels are emitted and word_cnt does not wrap past ch_last. ch_last = 0: exactly one word is emitted.
- clear_i (synchronous, highest priority after reset):
  - Next cycle: state=COLLECT, plane_cnt=0, word_cnt=0, vld=0, busy_o=0, no packet_sent_o pulse. An in_fire in the same cycle is discarded.
  - trans_buf is not cleared.
- Async reset mid-packet discards all progress immediately.
- Backpressure: wordser_data_rdy_i low in SEND holds word_cnt and data. Bit-plane inputs are ignored outside COLLECT.

Test Plan:
- Single packet, ch_last=3, planes chosen so channel k holds 0x10+k, rdy always 1 -> words 0x10,0x11,0x12,0x13 on 4 consecutive cycles; vld rises 1 cycle after the 8th in_fire; packet_sent_o pulses once; rdy_o returns high.
- Full width MAX=128, ch_last=127, random bytes, random vld gaps on input and random rdy on output -> all 128 words match the scoreboard in order; data holds stable during every rdy=0 stall.
- ch_last=0 with byte 0xA5 in channel 0 -> exactly one word 0xA5; packet_sent_o is asserted the cycle after that out_fire.
- channel_num_i changed from 5 to 2 after the 1st plane -> 6 words emitted (ch_last latched at 5).
- clear_i asserted at plane 4, and separately at word 2 of 6 -> next cycle state is COLLECT, vld=0, busy_o=0, no packet_sent_o; the following full packet transposes correctly.
- rst_n_i pulsed low mid-SEND -> all outputs take their reset values immediately; the next packet is correct; two back-to-back packets show no overlap (rdy_o stays 0 throughout SEND).
